skintone_score_pipe: RTL and testbench
======================================

Name: skintone_score_pipe

Overview:
- Parametrised successor of the single-lane skintone scoring datapath.
- Takes LANES pre-transformed chroma pairs (Cb', Cr') per beat, each in signed fixed point.
- Runs the elliptical skin model per lane and emits one 8-bit skin score per lane.
- Adds ready/valid backpressure and run-time programmable model constants. Sits between the transcb/transcr front end and the downstream mask/score buffer.

Parameters:
- LANES, 2, pixels processed per beat.
- FP_WIDTH, 32, signed fixed-point word width.
- FP_FRAC, 16, fractional bits; must satisfy FP_FRAC+8 <= FP_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&&in_ready.
- in_cb  in  LANES*FP_WIDTH  transformed Cb per lane; lane k at [k*FP_WIDTH +: FP_WIDTH].
- in_cr  in  LANES*FP_WIDTH  transformed Cr per lane, same packing.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_score  out  LANES*8  skin score per lane; lane k at [k*8 +: 8].
- cfg_we  in  1  write shadow constant.
- cfg_addr  in  4  0 Cx, 1 Cy, 2 cos, 3 sin, 4 ECx, 5 ECy, 6 A2_inv, 7 B2_inv, 8 Radius, 9 fac; addresses 10-15 are ignored.
- cfg_wdata  in  FP_WIDTH  constant value.
- cfg_commit  in  1  request shadow-to-active copy.
- cfg_busy  out  1  commit pending.

Behaviour:
- Reset: all valid bits 0, out_valid 0, out_score 0, cfg_busy 0, FSM IDLE. Shadow and active banks reset to the datapath.vh defaults (`Cx_fp … `fac_fp`).
- Arithmetic: two's complement, FP_WIDTH wrap on add/sub. Multiply uses fp_mult semantics: full product arithmetic-shifted right by FP_FRAC, truncated to FP_WIDTH.
- Per-lane pipeline, one register per stage, 10 stages. Latency is 10 cycles from accept to out_valid with no stall.
  - S1: x0 = cb−Cx; y0 = Cy−cr.
  - S2: p0 = cos·x0, p1 = sin·y0, p2 = −sin·x0, p3 = cos·y0.
  - S3: u = p0+p1; v = p2+p3.
  - S4: x = ECx−u; y = v−ECy (each axis uses its own rotated term).
  - S5: x², y².
  - S6: A2_inv·x², B2_inv·y².
  - S7: d = sum.
  - S8: r = Radius−d; in = (d <= Radius), signed compare.
  - S9: m = fac·r; in delayed.
  - S10: score = in ? m[FP_FRAC+7:FP_FRAC] : 0.
- Stall: adv = ~out_valid | out_ready. When adv=0 every stage holds, including the valid bits. in_ready = adv && state==IDLE. Bubbles are not collapsed.
- out_score holds stable while out_valid && ~out_ready.
- Config FSM:
  - IDLE: cfg_commit -> PEND.
  - PEND: in_ready=0. When all 10 valid bits are 0, copy shadow to active -> IDLE.
  - cfg_busy = (state==PEND).
  - cfg_we writes the shadow bank in any state. A write in the same cycle as the copy lands in shadow only, and the copy uses the pre-write shadow value.
  - cfg_commit while already in PEND is ignored.
- Reset asserted mid-stream clears all valids and the FSM; in-flight beats are lost. Active constants return to their defaults.

Optional Feature:
- SKINTONE_SAT_EN defined: S10 saturates. A negative m cannot occur when in=1. Any m >= 256.0 gives 255; otherwise the truncated integer bits.
- Not defined: plain bit slice as above, so 400.0 yields 144.

Decomposition:
- Package skintone_pkg: cfg address enum, default constant values, FP_WIDTH/FP_FRAC defaults, stage count LAT=10.
- Sub-module skintone_score_lane: one lane's 10-stage datapath with an adv enable input and the active constants as inputs. The top instantiates LANES copies plus the valid shift chain, the config banks and the FSM.
- fp_mult is reused from the existing codebase.

Test Plan:
- Setup for 1-3: cfg Cx=Cy=ECx=ECy=0, cos=1.0, sin=0, A2_inv=B2_inv=1.0, Radius=1.0, fac=200.0, then commit.
  1. Lanes (cb,cr) = (0,0),(0.5,0) -> scores 200 and 150, out_valid exactly 10 cycles after accept.
  2. Lane (2.0,0) -> d=4.0 > Radius -> score 0. Lane (0,1.0) -> d=1.0, boundary inclusive -> score 0 via r=0.
  3. 30-beat stream with out_ready held low for cycles 12-16 -> in_ready low those cycles, out_score stable, all 30 beats delivered in order with none duplicated.
- 4. fac=400.0, input (0,0) -> 144 without SKINTONE_SAT_EN, 255 with it.
- 5. cfg_commit (fac=100.0) with 5 beats in flight -> cfg_busy high and in_ready low until drain. The 5 old beats score 200, the next accepted beat scores 100.
- 6. rst_n pulsed low mid-stream -> out_valid 0 immediately (asynchronous), constants at defaults, next beat has 10-cycle latency.

Source files
------------

// File: rtl/skintone_pkg.sv
// Shared types and constants for the skintone scoring pipeline: config address
// map, config FSM states, default model constants and pipeline depth.
package skintone_pkg;

   localparam int LANES_DEF    = 2;
   localparam int FP_WIDTH_DEF = 32;
   localparam int FP_FRAC_DEF  = 16;
   localparam int LAT          = 10;
   localparam int NUM_CFG      = 10;

   typedef enum logic [3:0] {
      CFG_CX     = 4'd0,
      CFG_CY     = 4'd1,
      CFG_COS    = 4'd2,
      CFG_SIN    = 4'd3,
      CFG_ECX    = 4'd4,
      CFG_ECY    = 4'd5,
      CFG_A2_INV = 4'd6,
      CFG_B2_INV = 4'd7,
      CFG_RADIUS = 4'd8,
      CFG_FAC    = 4'd9
   } cfg_addr_e;

   typedef enum logic {
      ST_IDLE,
      ST_PEND
   } cfg_state_e;

   // Default skin ellipse in Q16.16; the top rescales these to FP_FRAC.
   localparam logic [31:0] CFG_DEFAULT_Q16 [NUM_CFG] = '{
      32'h006D_6000,  // Cx      109.375
      32'h0098_0000,  // Cy      152.0
      32'hFFFF_2E70,  // cos     -0.8186 (theta 2.53 rad)
      32'h0000_930C,  // sin      0.5744
      32'h0001_A000,  // ECx      1.625
      32'h0002_6000,  // ECy      2.375
      32'h0000_0066,  // A2_inv   ~1/25.39^2
      32'h0000_014D,  // B2_inv   ~1/14.03^2
      32'h0001_0000,  // Radius   1.0
      32'h00FF_0000   // fac      255.0
   };

endpackage

// File: rtl/skintone_score_lane.sv
// One lane of the 10-stage elliptical skin model. All stages advance together on adv.
// Define SKINTONE_SAT_EN to saturate the final score at 255 instead of bit-slicing.
module skintone_score_lane
   import skintone_pkg::*;
#(
   parameter int FP_WIDTH = FP_WIDTH_DEF,
   parameter int FP_FRAC  = FP_FRAC_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       adv,
   input  logic signed [FP_WIDTH-1:0] cb,
   input  logic signed [FP_WIDTH-1:0] cr,
   input  logic signed [FP_WIDTH-1:0] c_cx,
   input  logic signed [FP_WIDTH-1:0] c_cy,
   input  logic signed [FP_WIDTH-1:0] c_cos,
   input  logic signed [FP_WIDTH-1:0] c_sin,
   input  logic signed [FP_WIDTH-1:0] c_ecx,
   input  logic signed [FP_WIDTH-1:0] c_ecy,
   input  logic signed [FP_WIDTH-1:0] c_a2_inv,
   input  logic signed [FP_WIDTH-1:0] c_b2_inv,
   input  logic signed [FP_WIDTH-1:0] c_radius,
   input  logic signed [FP_WIDTH-1:0] c_fac,
   output logic        [7:0]          score
);

   typedef logic signed [FP_WIDTH-1:0] fp_t;

   // Full-width signed product, arithmetic shift by FP_FRAC, truncate to FP_WIDTH.
   function automatic fp_t fp_mult(input fp_t a, input fp_t b);
      logic signed [2*FP_WIDTH-1:0] prod;
      prod = (2*FP_WIDTH)'(a) * (2*FP_WIDTH)'(b);
      return fp_t'(prod >>> FP_FRAC);
   endfunction

`ifdef SKINTONE_SAT_EN
   localparam logic signed [FP_WIDTH+1:0] SAT_LIM = (FP_WIDTH+2)'(256) <<< FP_FRAC;
`endif

   fp_t x0_q, x0_d, y0_q, y0_d;
   fp_t p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
   fp_t u_q, u_d, v_q, v_d;
   fp_t x_q, x_d, y_q, y_d;
   fp_t xx_q, xx_d, yy_q, yy_d;
   fp_t ax_q, ax_d, by_q, by_d;
   fp_t d_q, d_d;
   fp_t r_q, r_d;
   fp_t m_q, m_d;
   logic in8_q, in8_d, in9_q, in9_d;
   logic [7:0] score_q, score_d;

   always_comb begin
      x0_d  = cb - c_cx;
      y0_d  = c_cy - cr;
      p0_d  = fp_mult(c_cos, x0_q);
      p1_d  = fp_mult(c_sin, y0_q);
      p2_d  = -fp_mult(c_sin, x0_q);
      p3_d  = fp_mult(c_cos, y0_q);
      u_d   = p0_q + p1_q;
      v_d   = p2_q + p3_q;
      x_d   = c_ecx - u_q;
      y_d   = v_q - c_ecy;
      xx_d  = fp_mult(x_q, x_q);
      yy_d  = fp_mult(y_q, y_q);
      ax_d  = fp_mult(c_a2_inv, xx_q);
      by_d  = fp_mult(c_b2_inv, yy_q);
      d_d   = ax_q + by_q;
      r_d   = c_radius - d_q;
      in8_d = (d_q <= c_radius);
      m_d   = fp_mult(c_fac, r_q);
      in9_d = in8_q;
`ifdef SKINTONE_SAT_EN
      if (!in9_q)
         score_d = '0;
      else if ((FP_WIDTH+2)'(m_q) >= SAT_LIM)
         score_d = 8'hFF;
      else
         score_d = m_q[FP_FRAC+7:FP_FRAC];
`else
      score_d = in9_q ? m_q[FP_FRAC+7:FP_FRAC] : 8'h00;
`endif
   end

   // NOTE: sequential state uses nonblocking assignments so every stage samples
   // the previous stage's pre-edge value; blocking here would collapse stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0_q <= '0; y0_q <= '0;
         p0_q <= '0; p1_q <= '0; p2_q <= '0; p3_q <= '0;
         u_q  <= '0; v_q  <= '0;
         x_q  <= '0; y_q  <= '0;
         xx_q <= '0; yy_q <= '0;
         ax_q <= '0; by_q <= '0;
         d_q  <= '0;
         r_q  <= '0; in8_q <= 1'b0;
         m_q  <= '0; in9_q <= 1'b0;
         score_q <= '0;
      end else if (adv) begin
         x0_q <= x0_d; y0_q <= y0_d;
         p0_q <= p0_d; p1_q <= p1_d; p2_q <= p2_d; p3_q <= p3_d;
         u_q  <= u_d;  v_q  <= v_d;
         x_q  <= x_d;  y_q  <= y_d;
         xx_q <= xx_d; yy_q <= yy_d;
         ax_q <= ax_d; by_q <= by_d;
         d_q  <= d_d;
         r_q  <= r_d;  in8_q <= in8_d;
         m_q  <= m_d;  in9_q <= in9_d;
         score_q <= score_d;
      end
   end

   assign score = score_q;

endmodule

// File: rtl/skintone_score_pipe.sv
// LANES-wide skintone scorer: valid chain, ready/valid stall, shadow/active config
// banks with drain-then-commit FSM. SKINTONE_SAT_EN enables score saturation in the lanes.
module skintone_score_pipe
   import skintone_pkg::*;
#(
   parameter int LANES    = LANES_DEF,
   parameter int FP_WIDTH = FP_WIDTH_DEF,
   parameter int FP_FRAC  = FP_FRAC_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*FP_WIDTH-1:0] in_cb,
   input  logic [LANES*FP_WIDTH-1:0] in_cr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*8-1:0]        out_score,
   input  logic                      cfg_we,
   input  logic [3:0]                cfg_addr,
   input  logic [FP_WIDTH-1:0]       cfg_wdata,
   input  logic                      cfg_commit,
   output logic                      cfg_busy
);

   typedef logic [FP_WIDTH-1:0] word_t;

   function automatic word_t scale_default(input logic [31:0] q16);
      logic signed [FP_WIDTH+47:0] ext;
      ext = (FP_WIDTH+48)'($signed(q16));
      ext = ext <<< FP_FRAC;
      ext = ext >>> 16;
      return ext[FP_WIDTH-1:0];
   endfunction

   cfg_state_e     state_q, state_d;
   logic [LAT-1:0] valid_q, valid_d;
   word_t          shadow_q [NUM_CFG];
   word_t          shadow_d [NUM_CFG];
   word_t          active_q [NUM_CFG];
   word_t          active_d [NUM_CFG];
   logic           adv, accept, drained, copy;

   assign adv       = ~valid_q[LAT-1] | out_ready;
   assign in_ready  = adv && (state_q == ST_IDLE);
   assign accept    = in_valid && in_ready;
   assign drained   = (valid_q == '0);
   assign out_valid = valid_q[LAT-1];
   assign cfg_busy  = (state_q == ST_PEND);

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      copy    = 1'b0;
      case (state_q)
         ST_IDLE: if (cfg_commit) state_d = ST_PEND;
         ST_PEND: begin
            if (drained) begin
               copy    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      valid_d = adv ? {valid_q[LAT-2:0], accept} : valid_q;
   end

   // The copy reads shadow_q, so a same-cycle write reaches the shadow bank only.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (cfg_we && (cfg_addr < 4'(NUM_CFG)))
         shadow_d[cfg_addr] = cfg_wdata;
      if (copy)
         active_d = shadow_q;
   end

   // NOTE: the constant banks are small flop arrays, not RAM, so they can and
   // do take a reset value; a real memory macro would not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         valid_q <= '0;
         for (int i = 0; i < NUM_CFG; i++) begin
            shadow_q[i] <= scale_default(CFG_DEFAULT_Q16[i]);
            active_q[i] <= scale_default(CFG_DEFAULT_Q16[i]);
         end
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      skintone_score_lane #(
         .FP_WIDTH (FP_WIDTH),
         .FP_FRAC  (FP_FRAC)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .adv      (adv),
         .cb       (in_cb[k*FP_WIDTH +: FP_WIDTH]),
         .cr       (in_cr[k*FP_WIDTH +: FP_WIDTH]),
         .c_cx     (active_q[CFG_CX]),
         .c_cy     (active_q[CFG_CY]),
         .c_cos    (active_q[CFG_COS]),
         .c_sin    (active_q[CFG_SIN]),
         .c_ecx    (active_q[CFG_ECX]),
         .c_ecy    (active_q[CFG_ECY]),
         .c_a2_inv (active_q[CFG_A2_INV]),
         .c_b2_inv (active_q[CFG_B2_INV]),
         .c_radius (active_q[CFG_RADIUS]),
         .c_fac    (active_q[CFG_FAC]),
         .score    (out_score[k*8 +: 8])
      );
   end

endmodule

// File: tb/tb_skintone_score_pipe.sv
// Scoreboard bench for skintone_score_pipe: directed beats push expected scores,
// a negedge monitor pops and compares on every output handshake.
module tb_skintone_score_pipe;
   import skintone_pkg::*;

   localparam int LANES = 2;
   localparam int W     = 32;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [LANES*W-1:0] in_cb = '0;
   logic [LANES*W-1:0] in_cr = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [LANES*8-1:0] out_score;
   logic               cfg_we = 1'b0;
   logic [3:0]         cfg_addr = '0;
   logic [W-1:0]       cfg_wdata = '0;
   logic               cfg_commit = 1'b0;
   logic               cfg_busy;

   skintone_score_pipe #(.LANES(LANES), .FP_WIDTH(W), .FP_FRAC(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_cb      (in_cb),
      .in_cr      (in_cr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_score  (out_score),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_commit (cfg_commit),
      .cfg_busy   (cfg_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] score;
      int          stamp;
      bit          chk_lat;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          hold_vld = 0;
   logic [15:0] hold_score = '0;

   // score for (k/8)^2 distance with fac=200, R=1: floor(200*(64-k^2)/64)
   logic [7:0] tbl [8] = '{8'd200, 8'd196, 8'd187, 8'd171, 8'd150, 8'd121, 8'd87, 8'd46};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            hold_vld = 0;
            check("output_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check("score", 32'(out_score), 32'(e.score));
               if (e.chk_lat) check("latency", 32'(cyc - e.stamp), 10);
            end
         end else if (out_valid) begin
            if (hold_vld) check("stall_hold", 32'(out_score), 32'(hold_score));
            hold_vld   = 1;
            hold_score = out_score;
            check("stall_in_ready", 32'(in_ready), 0);
         end else begin
            hold_vld = 0;
         end
         if (cfg_busy) check("busy_in_ready", 32'(in_ready), 0);
      end
   end

   task automatic cfg_write(input cfg_addr_e a, input logic [31:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic commit();
      cfg_commit = 1'b1;
      @(posedge clk); #1;
      cfg_commit = 1'b0;
      @(negedge clk);
      check("busy_after_commit", 32'(cfg_busy), 1);
      for (int i = 0; i < 200 && cfg_busy; i++) @(negedge clk);
      check("commit_done", 32'(cfg_busy), 0);
      @(posedge clk); #1;
   endtask

   task automatic send_beat(input logic [31:0] cb0, input logic [31:0] cr0,
                            input logic [31:0] cb1, input logic [31:0] cr1,
                            input logic [7:0] e0, input logic [7:0] e1, input bit lat);
      bit got;
      got      = 0;
      in_valid = 1'b1;
      in_cb    = {cb1, cb0};
      in_cr    = {cr1, cr0};
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{score: {e1, e0}, stamp: cyc, chk_lat: lat});
            got = 1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("beat_accepted", 32'(got), 1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
      check("drain", 32'(sb.size()), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_sat;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_out_score", 32'(out_score), 0);
      check("reset_cfg_busy", 32'(cfg_busy), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Unit circle, no rotation, fac = 200
      cfg_write(CFG_CX, 32'h0);
      cfg_write(CFG_CY, 32'h0);
      cfg_write(CFG_COS, 32'h0001_0000);
      cfg_write(CFG_SIN, 32'h0);
      cfg_write(CFG_ECX, 32'h0);
      cfg_write(CFG_ECY, 32'h0);
      cfg_write(CFG_A2_INV, 32'h0001_0000);
      cfg_write(CFG_B2_INV, 32'h0001_0000);
      cfg_write(CFG_RADIUS, 32'h0001_0000);
      cfg_write(CFG_FAC, 32'h00C8_0000);
      commit();

      // 1: centre and half radius
      send_beat(32'h0, 32'h0, 32'h0000_8000, 32'h0, 8'd200, 8'd150, 1);
      wait_drain();

      // 2: outside, and exactly on the boundary
      send_beat(32'h0002_0000, 32'h0, 32'h0, 32'h0001_0000, 8'd0, 8'd0, 1);
      wait_drain();

      // 3: 30-beat stream with a 5-cycle downstream stall
      fork
         begin
            for (int b = 0; b < 30; b++) begin
               int i, j;
               i = b % 8;
               j = (3 * b + 1) % 8;
               send_beat(32'(i * 8192), 32'h0, 32'h0, 32'(j * 8192), tbl[i], tbl[j], 0);
            end
         end
         begin
            repeat (12) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain();

      // 4: fac = 400 overflows the 8-bit score
`ifdef SKINTONE_SAT_EN
      exp_sat = 8'd255;
`else
      exp_sat = 8'd144;
`endif
      cfg_write(CFG_FAC, 32'h0190_0000);
      commit();
      send_beat(32'h0, 32'h0, 32'h0, 32'h0, exp_sat, exp_sat, 1);
      wait_drain();

      // 5: commit fac = 100 while 5 beats scored with fac = 200 are in flight
      cfg_write(CFG_FAC, 32'h00C8_0000);
      commit();
      cfg_write(CFG_FAC, 32'h0064_0000);
      for (int b = 0; b < 5; b++)
         send_beat(32'h0, 32'h0, 32'h0, 32'h0, 8'd200, 8'd200, 0);
      cfg_commit = 1'b1;
      @(posedge clk); #1;
      cfg_commit = 1'b0;
      @(negedge clk);
      check("pend_busy", 32'(cfg_busy), 1);
      check("pend_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      send_beat(32'h0, 32'h0, 32'h0, 32'h0, 8'd100, 8'd100, 0);
      wait_drain();

      // 6: reset mid-stream; defaults return (centre of default ellipse scores 246)
      for (int b = 0; b < 12; b++)
         send_beat(32'h0, 32'h0, 32'h0, 32'h0, 8'd100, 8'd100, 0);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_out_valid", 32'(out_valid), 0);
      check("async_reset_busy", 32'(cfg_busy), 0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_beat(CFG_DEFAULT_Q16[CFG_CX], CFG_DEFAULT_Q16[CFG_CY],
                CFG_DEFAULT_Q16[CFG_CX], CFG_DEFAULT_Q16[CFG_CY], 8'd246, 8'd246, 1);
      wait_drain();

      repeat (5) @(posedge clk);
      #1;
      check("final_idle", 32'(out_valid), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
